// File: rtl/onehot_encoder_pipe_if.sv
// Handshake bundle for the pipelined one-hot encoder.
// master = producer/consumer side, slave = encoder side.
interface onehot_encoder_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     dec_vld;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH_LOG-1:0] enc_idx;
    logic                 enc_vld;
    logic                 enc_err;
    logic                 err_clr;
    logic [CNT_WIDTH-1:0] err_cnt;

    modport master (
        output in_valid,
        output dec_vld,
        output out_ready,
        output err_clr,
        input  in_ready,
        input  out_valid,
        input  enc_idx,
        input  enc_vld,
        input  enc_err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  dec_vld,
        input  out_ready,
        input  err_clr,
        output in_ready,
        output out_valid,
        output enc_idx,
        output enc_vld,
        output enc_err,
        output err_cnt
    );
endinterface

// File: rtl/onehot_encoder_pipe.sv
// Pipelined one-hot to binary encoder with valid/ready flow
// control and a saturating counter of delivered multi-hot results.
module onehot_encoder_pipe #(
    parameter int WIDTH          = 32,
    parameter int STAGES         = 2,
    parameter int CNT_WIDTH      = 8,
    parameter int IMPLEMENTATION = 0
) (
    input  logic clk,
    input  logic rst_n,
    onehot_encoder_pipe_if.slave bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int DW        = WIDTH_LOG + 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "onehot_encoder_pipe: WIDTH must be >= 2");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $fatal(1, "onehot_encoder_pipe: STAGES must be 1..4");
    end
    if (IMPLEMENTATION != 0 && IMPLEMENTATION != 1) begin : g_bad_impl
        $fatal(1, "onehot_encoder_pipe: IMPLEMENTATION must be 0 or 1");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $fatal(1, "onehot_encoder_pipe: CNT_WIDTH must be >= 1");
    end

    // Positions whose index has bit b set.
    function automatic logic [WIDTH-1:0] bit_mask(input int b);
        logic [WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = ((i >> b) & 1) != 0;
        end
        return m;
    endfunction

    logic [WIDTH_LOG-1:0] w_idx;
    logic                 w_any;
    logic                 w_multi;

    assign w_any = |bus.dec_vld;
    // x & (x-1) clears the lowest set bit; nonzero means two or more.
    assign w_multi = |(bus.dec_vld & (bus.dec_vld - WIDTH'(1)));

    if (IMPLEMENTATION == 0) begin : g_enc_loop
        // OR together the indices of every set bit.
        always_comb begin
            w_idx = '0;
            for (int i = 0; i < WIDTH; i++) begin
                if (bus.dec_vld[i]) begin
                    w_idx = w_idx | WIDTH_LOG'(i);
                end
            end
        end
    end else begin : g_enc_table
        for (genvar b = 0; b < WIDTH_LOG; b++) begin : g_bit
            assign w_idx[b] = |(bus.dec_vld & bit_mask(b));
        end
    end

    logic [STAGES-1:0] r_vld;
    logic [DW-1:0]     r_dat  [STAGES];
    logic [STAGES-1:0] w_load;
    logic [STAGES-1:0] w_up_v;
    logic [DW-1:0]     w_up_d [STAGES];
    logic              r_rdy;
    logic              w_in_fire;

    // A stage may load if it or any stage downstream has room,
    // or the sink takes the last stage this cycle.
    always_comb begin
        logic acc;
        acc = bus.out_ready;
        w_load = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc = acc | ~r_vld[k];
            w_load[k] = acc;
        end
    end

    assign bus.in_ready = r_rdy & w_load[0];
    assign w_in_fire    = bus.in_valid & bus.in_ready;

    // Upstream source for each stage: encoder for the first one.
    always_comb begin
        w_up_v    = '0;
        w_up_v[0] = w_in_fire;
        w_up_d[0] = {w_idx, w_any, w_multi};
        for (int k = 1; k < STAGES; k++) begin
            w_up_v[k] = r_vld[k-1];
            w_up_d[k] = r_dat[k-1];
        end
    end

    // Input is held off until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    // Stage registers; data only moves when a valid word arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k] <= w_up_v[k];
                    if (w_up_v[k]) begin
                        r_dat[k] <= w_up_d[k];
                    end
                end
            end
        end
    end

    assign bus.out_valid = r_vld[STAGES-1];
    assign {bus.enc_idx, bus.enc_vld, bus.enc_err} = r_dat[STAGES-1];

    logic w_inc;
    assign w_inc = bus.out_valid & bus.out_ready & bus.enc_err;

    // Saturating error counter; a clear that coincides with an
    // increment counts the new event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.err_cnt <= '0;
        end else if (w_inc) begin
            if (bus.err_clr) begin
                bus.err_cnt <= CNT_WIDTH'(1);
            end else if (bus.err_cnt != CNT_MAX) begin
                bus.err_cnt <= bus.err_cnt + CNT_WIDTH'(1);
            end
        end else if (bus.err_clr) begin
            bus.err_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_onehot_encoder_pipe.sv
// Bench for onehot_encoder_pipe: four configurations share one
// input stream, each checked against its own queue model.
module tb_onehot_encoder_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] dec_vld = '0;
    logic        err_clr = 1'b0;
    logic [3:0]  ordy = 4'hF;

    logic [3:0]      irdy, ovld, oev, oee;
    logic [3:0][4:0] oidx;
    logic [3:0][7:0] ecnt;

    always #5 clk = ~clk;

    onehot_encoder_pipe_if #(.WIDTH(32), .CNT_WIDTH(8)) b0 ();
    onehot_encoder_pipe_if #(.WIDTH(32), .CNT_WIDTH(2)) b1 ();
    onehot_encoder_pipe_if #(.WIDTH(32), .CNT_WIDTH(8)) b2 ();
    onehot_encoder_pipe_if #(.WIDTH(32), .CNT_WIDTH(8)) b3 ();

    onehot_encoder_pipe #(.WIDTH(32), .STAGES(2), .CNT_WIDTH(8),
        .IMPLEMENTATION(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    onehot_encoder_pipe #(.WIDTH(32), .STAGES(3), .CNT_WIDTH(2),
        .IMPLEMENTATION(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    onehot_encoder_pipe #(.WIDTH(32), .STAGES(1), .CNT_WIDTH(8),
        .IMPLEMENTATION(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
    onehot_encoder_pipe #(.WIDTH(32), .STAGES(4), .CNT_WIDTH(8),
        .IMPLEMENTATION(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

    assign b0.in_valid = in_valid;
    assign b1.in_valid = in_valid;
    assign b2.in_valid = in_valid;
    assign b3.in_valid = in_valid;
    assign b0.dec_vld = dec_vld;
    assign b1.dec_vld = dec_vld;
    assign b2.dec_vld = dec_vld;
    assign b3.dec_vld = dec_vld;
    assign b0.err_clr = err_clr;
    assign b1.err_clr = err_clr;
    assign b2.err_clr = err_clr;
    assign b3.err_clr = err_clr;
    assign b0.out_ready = ordy[0];
    assign b1.out_ready = ordy[1];
    assign b2.out_ready = ordy[2];
    assign b3.out_ready = ordy[3];

    assign irdy = {b3.in_ready, b2.in_ready, b1.in_ready, b0.in_ready};
    assign ovld = {b3.out_valid, b2.out_valid, b1.out_valid, b0.out_valid};
    assign oev  = {b3.enc_vld, b2.enc_vld, b1.enc_vld, b0.enc_vld};
    assign oee  = {b3.enc_err, b2.enc_err, b1.enc_err, b0.enc_err};
    assign oidx[0] = b0.enc_idx;
    assign oidx[1] = b1.enc_idx;
    assign oidx[2] = b2.enc_idx;
    assign oidx[3] = b3.enc_idx;
    assign ecnt[0] = b0.err_cnt;
    assign ecnt[1] = {6'd0, b1.err_cnt};
    assign ecnt[2] = b2.err_cnt;
    assign ecnt[3] = b3.err_cnt;

    int st[4]   = '{2, 3, 1, 4};
    int cmax[4] = '{255, 3, 255, 255};

    logic [6:0] sb_d [4][64];
    int         sb_t [4][64];
    int         wp[4], rp[4], mcnt[4], acc[4];
    logic [3:0] stall;
    logic [6:0] held[4];
    int         cyc, passed, failed, total;
    bit         lat_chk, seen;

    // Spec-level reference: OR of set-bit indices, popcount tests.
    function automatic logic [6:0] ref_enc(input logic [31:0] d);
        int n, ix;
        n = 0;
        ix = 0;
        for (int i = 0; i < 32; i++) begin
            if (d[i]) begin
                n++;
                ix = ix | i;
            end
        end
        return {5'(ix), n > 0, n > 1};
    endfunction

    function automatic logic [31:0] rnd_vec();
        int s;
        logic [31:0] one;
        s = int'($urandom_range(9, 0));
        one = 32'h1;
        if (s < 2) return '0;
        if (s < 6) return one << $urandom_range(31, 0);
        if (s < 8) return (one << $urandom_range(31, 0)) |
                          (one << $urandom_range(31, 0));
        return $urandom();
    endfunction

    task automatic chk(input string tag, input int k,
                       input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s[%0d]: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One clock: check at the falling edge, then advance past the rise.
    task automatic step();
        logic [6:0] got, e;
        bit xe;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            got = {oidx[k], oev[k], oee[k]};
            chk("err_cnt", k, 32'(ecnt[k]), 32'(mcnt[k]));
            if (stall[k]) begin
                chk("hold_valid", k, 32'(ovld[k]), 32'd1);
                chk("hold_data", k, 32'(got), 32'(held[k]));
            end
            xe = 1'b0;
            stall[k] = 1'b0;
            if (ovld[k]) begin
                if (wp[k] == rp[k]) begin
                    chk("stale", k, 32'(ovld[k]), 32'd0);
                end else begin
                    e = sb_d[k][rp[k] % 64];
                    chk("result", k, 32'(got), 32'(e));
                    if (lat_chk && ordy[k])
                        chk("latency", k, cyc - sb_t[k][rp[k] % 64], st[k]);
                    if (ordy[k]) begin
                        xe = e[0];
                        rp[k]++;
                    end else begin
                        stall[k] = 1'b1;
                        held[k] = got;
                    end
                end
            end
            if (xe)
                mcnt[k] = err_clr ? 1 :
                          (mcnt[k] == cmax[k] ? mcnt[k] : mcnt[k] + 1);
            else if (err_clr)
                mcnt[k] = 0;
            if (in_valid && irdy[k]) begin
                sb_d[k][wp[k] % 64] = ref_enc(dec_vld);
                sb_t[k][wp[k] % 64] = cyc;
                wp[k]++;
                acc[k]++;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_valid = 1'b1;
        dec_vld = d;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_out_valid", k, 32'(ovld[k]), 32'd0);
            chk("rst_err_cnt", k, 32'(ecnt[k]), 32'd0);
            chk("rst_in_ready", k, 32'(irdy[k]), 32'd0);
            chk("rst_enc", k, 32'({oidx[k], oev[k], oee[k]}), 32'd0);
            rp[k] = wp[k];
            mcnt[k] = 0;
        end
        stall = '0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++)
            chk("ready_before_edge", k, 32'(irdy[k]), 32'd0);
        step();
        for (int k = 0; k < 4; k++)
            chk("ready_after_rst", k, 32'(irdy[k]), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            wp[k] = 0;
            rp[k] = 0;
            mcnt[k] = 0;
            acc[k] = 0;
        end
        stall = '0;
        cyc = 0;
        passed = 0;
        failed = 0;
        total = 0;
        lat_chk = 1'b0;
        #1;
        do_reset();

        lat_chk = 1'b1;
        send(32'h0000_0001);
        send(32'h0000_0020);
        send(32'h8000_0000);
        idle(6);
        send(32'h0000_0000);
        send(32'h0000_0006);
        idle(6);
        lat_chk = 1'b0;

        for (int k = 0; k < 4; k++) acc[k] = 0;
        ordy = 4'h0;
        for (int i = 0; i < 5; i++) send(32'h8 << i);
        for (int k = 0; k < 4; k++) begin
            chk("accepted", k, 32'(acc[k]), 32'(st[k]));
            chk("stall_in_ready", k, 32'(irdy[k]), 32'd0);
        end
        in_valid = 1'b0;
        ordy = 4'hF;
        idle(8);

        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        repeat (5) send(32'h0000_0003);
        idle(6);
        chk("saturate", 1, 32'(ecnt[1]), 32'd3);
        send(32'h0000_0003);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            in_valid = 1'b0;
            err_clr = ovld[1];
            seen = ovld[1];
            step();
        end
        err_clr = 1'b0;
        chk("clr_seen", 1, 32'(seen), 32'd1);
        chk("clr_with_inc", 1, 32'(ecnt[1]), 32'd1);
        idle(6);

        send(32'h0000_0005);
        send(32'h0000_0300);
        do_reset();
        idle(8);

        for (int i = 0; i < 3000; i++) begin
            in_valid = ($urandom_range(3, 0) != 0);
            ordy = 4'($urandom());
            dec_vld = rnd_vec();
            err_clr = ($urandom_range(31, 0) == 0);
            step();
        end
        in_valid = 1'b0;
        err_clr = 1'b0;
        ordy = 4'hF;
        idle(10);
        for (int k = 0; k < 4; k++)
            chk("drained", k, 32'(wp[k] - rp[k]), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
